// File: rtl/psram_line_pkg.sv
// -----------------------------------------------------------------------------
// psram_line_pkg
// Definitions shared by the PSRAM line packer and unpacker.
//   - geometry of one line burst: pixel width, lanes per beat, beats per burst
//   - index and address widths
//   - FSM state encoding
//   - helpers that map a pixel index to its beat and its lane
// -----------------------------------------------------------------------------
package psram_line_pkg;

   localparam int PIX_W     = 16;
   localparam int LANES     = 4;
   localparam int BURST_LEN = 8;
   localparam int IDX_W     = 5;
   localparam int ADDR_W    = 21;

   localparam int LANE_W = 2;          // log2(LANES)
   localparam int BEAT_W = 3;          // log2(BURST_LEN)
   localparam int CNT_W  = BEAT_W + 1; // beat count must be able to hold BURST_LEN
   localparam int PTR_W  = IDX_W + 1;  // extra bit so that end index 31 does not wrap

   localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RECV = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Beat that carries a given pixel.
   function automatic logic [BEAT_W-1:0] pix_beat(input logic [IDX_W-1:0] pix);
      return pix[IDX_W-1:LANE_W];
   endfunction

   // Lane within the beat that carries a given pixel (lane 0 = least significant bits).
   function automatic logic [LANE_W-1:0] pix_lane(input logic [IDX_W-1:0] pix);
      return pix[LANE_W-1:0];
   endfunction

endpackage

// File: rtl/psram_line_buf.sv
// -----------------------------------------------------------------------------
// psram_line_buf
// Line buffer of BURST_LEN beats, LANES*PIX_W bits each.
// One synchronous write port (whole beat) and one combinational read port that
// returns a single pixel selected by its line index.
//   i_clk    clock
//   i_we     write enable
//   i_waddr  beat slot to write
//   i_wdata  beat data
//   i_rpix   pixel index to read
//   o_rdata  selected pixel
// The storage has no reset: a slot is only read after it has been written
// within the current burst.
// -----------------------------------------------------------------------------
module psram_line_buf
   import psram_line_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_we,
   input  logic [BEAT_W-1:0]        i_waddr,
   input  logic [LANES*PIX_W-1:0]   i_wdata,
   input  logic [IDX_W-1:0]         i_rpix,
   output logic [PIX_W-1:0]         o_rdata
);

   logic [LANES*PIX_W-1:0] mem_q [BURST_LEN];
   logic [LANES*PIX_W-1:0] beat_s;

   // Beat write port.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   // Pixel read port: pick the beat, then the lane inside it.
   always_comb begin
      beat_s = mem_q[pix_beat(i_rpix)];
      case (pix_lane(i_rpix))
         2'd0:    o_rdata = beat_s[0*PIX_W +: PIX_W];
         2'd1:    o_rdata = beat_s[1*PIX_W +: PIX_W];
         2'd2:    o_rdata = beat_s[2*PIX_W +: PIX_W];
         default: o_rdata = beat_s[3*PIX_W +: PIX_W];
      endcase
   end

endmodule

// File: rtl/psram_line_unpacker.sv
// -----------------------------------------------------------------------------
// psram_line_unpacker
// Fetches one line burst from PSRAM and streams a sub-range of its pixels.
// A start pulse latches the base address and the pixel range, one read burst
// is requested, incoming beats are stored in psram_line_buf, and pixels
// start_index..end_index are presented in order as soon as their beat is in.
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_addr                    burst base address (sampled with i_start)
//   i_start_index/end_index   pixel range to emit (sampled with i_start)
//   i_start                   start pulse, honoured only when idle or done
//   o_busy, o_done            operation in progress / one-cycle completion
//   o_psram_read_req/addr     read request towards the arbiter, held to grant
//   i_psram_read_gnt          arbiter grant
//   i_psram_rdata(_valid)     read beats
//   o_pix_valid/data          registered pixel stream
//   i_pix_ready               downstream accept
// -----------------------------------------------------------------------------
module psram_line_unpacker
   import psram_line_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [ADDR_W-1:0]        i_addr,
   input  logic [IDX_W-1:0]         i_start_index,
   input  logic [IDX_W-1:0]         i_end_index,
   input  logic                     i_start,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_psram_read_req,
   input  logic                     i_psram_read_gnt,
   output logic [ADDR_W-1:0]        o_psram_addr,
   input  logic [LANES*PIX_W-1:0]   i_psram_rdata,
   input  logic                     i_psram_rdata_valid,
   output logic                     o_pix_valid,
   output logic [PIX_W-1:0]         o_pix_data,
   input  logic                     i_pix_ready
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [PTR_W-1:0]    end_q, end_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                req_q, req_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                pix_valid_q, pix_valid_d;
   logic [PIX_W-1:0]    pix_data_q, pix_data_d;

   logic                active_s;
   logic                slot_free_s;
   logic                pix_avail_s;
   logic                last_acc_s;
   logic                we_s;
   logic [PIX_W-1:0]    rd_pix_s;

   psram_line_buf u_buf (
      .i_clk   (i_clk),
      .i_we    (we_s),
      .i_waddr (cnt_q[BEAT_W-1:0]),
      .i_wdata (i_psram_rdata),
      .i_rpix  (ptr_q[IDX_W-1:0]),
      .o_rdata (rd_pix_s)
   );

   // State and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= {ADDR_W{1'b0}};
         end_q       <= {PTR_W{1'b0}};
         ptr_q       <= {PTR_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         req_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= {PIX_W{1'b0}};
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         end_q       <= end_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
      end
   end

   // Next-state logic: beat capture, pixel streaming and sequencing.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      end_d       = end_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      busy_d      = busy_q;
      pix_valid_d = pix_valid_q;
      pix_data_d  = pix_data_q;
      we_s        = 1'b0;

      active_s    = (state_q == ST_REQ) || (state_q == ST_RECV);
      // Output register can take a new pixel when empty or being drained now.
      slot_free_s = !pix_valid_q || i_pix_ready;
      // Pointer is one bit wider than an index, so ptr > end ends the range cleanly.
      pix_avail_s = active_s && (ptr_q <= end_q) &&
                    ({1'b0, pix_beat(ptr_q[IDX_W-1:0])} < cnt_q);
      last_acc_s  = (ptr_q > end_q) && slot_free_s;

      // Beats are stored only while a burst is outstanding; extras are dropped.
      if (active_s && i_psram_rdata_valid && (cnt_q < BURST_CNT)) begin
         we_s  = 1'b1;
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         we_s  = 1'b0;
      end

      // Pixel output register: load when free, hold while stalled.
      if (slot_free_s) begin
         if (pix_avail_s) begin
            pix_valid_d = 1'b1;
            pix_data_d  = rd_pix_s;
            ptr_d       = ptr_q + PTR_ONE;
         end else begin
            pix_valid_d = 1'b0;
         end
      end else begin
         pix_valid_d = pix_valid_q;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A new start is also taken in the completion cycle.
            if (i_start) begin
               addr_d      = i_addr;
               end_d       = {1'b0, i_end_index};
               ptr_d       = {1'b0, i_start_index};
               cnt_d       = {CNT_W{1'b0}};
               pix_valid_d = 1'b0;
               if (i_start_index > i_end_index) begin
                  state_d = ST_DONE;
                  req_d   = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_REQ;
                  req_d   = 1'b1;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               busy_d  = 1'b0;
            end
         end
         ST_REQ: begin
            if (i_psram_read_gnt) begin
               state_d = ST_RECV;
               req_d   = 1'b0;
            end else begin
               req_d   = 1'b1;
            end
         end
         ST_RECV: begin
            // Finish only once the whole burst is in, even if the range ended early.
            if (last_acc_s && (cnt_q == BURST_CNT)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
            end else begin
               state_d = ST_RECV;
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase

      done_d = (state_d == ST_DONE);
   end

   assign o_busy           = busy_q;
   assign o_done           = done_q;
   assign o_psram_read_req = req_q;
   assign o_psram_addr     = addr_q;
   assign o_pix_valid      = pix_valid_q;
   assign o_pix_data       = pix_data_q;

endmodule

// File: doc/psram_line_unpacker.md
Name: psram_line_unpacker

Overview:
- Read-side counterpart of the line packer.
- On a start pulse it issues one PSRAM read burst (8 beats x 64 bits = 32 pixels of 16 bits) and captures the beats into a 4-lane line buffer.
- It streams pixels i_start_index..i_end_index, in order, to the video pipeline over a valid/ready interface.
- Pixels are released as soon as the beat holding them has arrived. It sits between the PSRAM arbiter read port and the HDMI pixel FIFO.

Parameters:
PIX_W, 16, pixel width
LANES, 4, pixels per beat
BURST_LEN, 8, beats per burst
IDX_W, 5, pixel index width (log2(LANES*BURST_LEN))
ADDR_W, 21, PSRAM word address width

Ports:
i_clk  in  1  single clock
i_rst  in  1  synchronous reset, active-high
i_addr  in  ADDR_W  burst base address, sampled with i_start
i_start_index  in  IDX_W  first pixel to emit, sampled with i_start
i_end_index  in  IDX_W  last pixel to emit, sampled with i_start
i_start  in  1  one-cycle start pulse
o_busy  out  1  high from the cycle after an accepted start until o_done
o_done  out  1  one-cycle completion pulse
o_psram_read_req  out  1  read request
i_psram_read_gnt  in  1  grant
o_psram_addr  out  ADDR_W  latched i_addr
i_psram_rdata  in  LANES*PIX_W  read beat
i_psram_rdata_valid  in  1  beat strobe
o_pix_valid  out  1  pixel valid
o_pix_data  out  PIX_W  pixel
i_pix_ready  in  1  downstream accept

Behaviour:
- Reset values: all outputs 0; state IDLE; beat count 0. Reset mid-operation returns to IDLE the next cycle and drops o_psram_read_req. Stray beats arriving afterwards are ignored.
- States: IDLE -> REQ -> RECV -> DONE -> IDLE.
- IDLE:
  - i_start latches address and indices and sets o_busy.
  - If start_index > end_index, go to DONE with no PSRAM access.
  - Otherwise go to REQ.
  - i_start in any other state is ignored.
- REQ:
  - o_psram_read_req is held high, with o_psram_addr stable, until i_psram_read_gnt is sampled high.
  - req deasserts the cycle after grant. State moves to RECV.
- Beat capture:
  - i_psram_rdata_valid is accepted in REQ and RECV only.
  - Beat b is written to buffer entry b and the beat count increments.
  - Beats beyond BURST_LEN are dropped.
- Pixel mapping:
  - Pixel p is beat p>>2, lane p[1:0].
  - Lane 0 = rdata[15:0], lane 3 = rdata[63:48].
- Streaming:
  - Read pointer starts at start_index.
  - Pixel p may be presented when (p>>2) < beat count. It is therefore valid at the earliest one cycle after its beat is strobed.
  - o_pix_valid and o_pix_data are registered. While valid && !ready, both hold stable.
  - On valid && ready the pointer increments.
  - After end_index is accepted, o_pix_valid drops the following cycle unless another pixel is pending.
  - Back-to-back transfers run at 1 pixel/clock.
- Completion:
  - DONE is entered when the last pixel has been accepted and all BURST_LEN beats have been received. The full burst is always consumed, even if end_index < 31.
  - DONE drives o_done = 1 for one cycle, clears o_busy, and returns to IDLE.
  - A new i_start is accepted in the cycle o_done is high.
- No pixel outside [start_index, end_index] is ever presented. end_index = 31 must not wrap the 5-bit pointer; the comparison uses IDX_W+1 bits.

Decomposition:
- Shared package psram_line_pkg holds:
  - PIX_W, LANES, BURST_LEN, IDX_W, ADDR_W
  - state enum (IDLE/REQ/RECV/DONE)
  - pixel-to-beat/lane helper functions
- The same package is reused by the packer.
- One sub-module: psram_line_buf, an 8x64 register file with 1 write port and 1 combinational 16-bit lane read port selected by pixel index.

Test Plan:
1. start=1, end=27; gnt <= req; 8 back-to-back beats with pixel p = {2p+1, 2p} (8 bits each); ready=1 -> 27 pixels out, 0x0302 through 0x3736 in order; exactly one o_done after the 8th beat; no other pixel.
2. start=0, end=31; beats spaced 3 cycles; ready toggling 1/0 -> 32 pixels in order. Pixel 4 is never valid before the cycle after beat 1. Data is stable while stalled.
3. start=end=31 -> single pixel 0x3F3E after the 8th beat, then o_done; pointer does not wrap to pixel 0.
4. start=5, end=3 -> o_psram_read_req never asserts; o_done pulses one cycle later.
5. i_rst asserted after 3 beats in RECV -> next cycle all outputs are 0; 5 further stray beats are ignored. A new start then yields a correct full transfer.
6. gnt delayed 10 cycles; i_start pulsed while busy -> req and addr held stable the whole time; second start ignored; exactly one burst and one o_done.
